// File: rtl/sha256_message_packer_if.sv
// Word-in, block-out and config channels of the SHA-256 message packer.
interface sha256_message_packer_if;
  logic [31:0]  word_in;
  logic [1:0]   word_in_bytes;
  logic         word_in_last;
  logic         word_in_valid;
  logic         word_in_ready;
  logic [511:0] data_out;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready;
  logic [63:0]  cfg_size;
  logic [1:0]   cfg_scheme;
  logic         cfg_last;
  logic         cfg_valid;
  logic         cfg_ready;

  modport master (
    output word_in, word_in_bytes, word_in_last, word_in_valid,
    input  word_in_ready,
    input  data_out, data_out_last, data_out_valid,
    output data_out_ready,
    input  cfg_size, cfg_scheme, cfg_last, cfg_valid,
    output cfg_ready
  );

  modport slave (
    input  word_in, word_in_bytes, word_in_last, word_in_valid,
    output word_in_ready,
    output data_out, data_out_last, data_out_valid,
    input  data_out_ready,
    output cfg_size, cfg_scheme, cfg_last, cfg_valid,
    input  cfg_ready
  );
endinterface

// File: rtl/sha256_message_packer.sv
// Packs 32-bit message words big-endian into 512-bit SHA-256 blocks.
// SHA256_PACKER_BYTESWAP_EN: byte-reverse each word for little-endian sources.
module sha256_message_packer #(
  parameter logic [1:0] SCHEME_ID = 2'd0
) (
  input logic clk,
  input logic rst,
  input logic en,
  input logic sync_rst,
  sha256_message_packer_if.slave bus
);

  typedef enum logic {FILL, SEND} state_e;

  state_e       state_q;
  logic [3:0]   wcnt_q;
  logic [60:0]  bcnt_q;
  logic [511:0] data_q;
  logic         dlast_q;
  logic         dvalid_q;
  logic         cvalid_q;
  logic         rdy_q;
  logic [63:0]  csize_q;

  logic [31:0]  sw;
  logic [31:0]  mask;
  logic [31:0]  mw;
  logic [2:0]   nb;
  logic [60:0]  bcnt_d;
  logic [8:0]   base;
  logic         acc;
  logic         done;

`ifdef SHA256_PACKER_BYTESWAP_EN
  assign sw = {bus.word_in[7:0], bus.word_in[15:8],
               bus.word_in[23:16], bus.word_in[31:24]};
`else
  assign sw = bus.word_in;
`endif

  // After an optional swap the kept bytes are always the high-order ones
  always_comb begin
    mask = '1;
    unique case (bus.word_in_bytes)
      2'd1:    mask = 32'hFF00_0000;
      2'd2:    mask = 32'hFFFF_0000;
      2'd3:    mask = 32'hFFFF_FF00;
      default: mask = '1;
    endcase
  end

  assign mw     = bus.word_in_last ? (sw & mask) : sw;
  assign nb     = (bus.word_in_last && bus.word_in_bytes != 2'd0)
                  ? {1'b0, bus.word_in_bytes} : 3'd4;
  assign bcnt_d = bcnt_q + 61'(nb);
  assign base   = {~wcnt_q, 5'd0};
  assign acc    = rdy_q & bus.word_in_valid;
  assign done   = (~dvalid_q | bus.data_out_ready)
                & (~cvalid_q | bus.cfg_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
      data_q   <= '0;
      dlast_q  <= 1'b0;
      dvalid_q <= 1'b0;
      cvalid_q <= 1'b0;
      rdy_q    <= 1'b1;
      csize_q  <= '0;
    end else if (en) begin
      if (sync_rst) begin
        state_q  <= FILL;
        wcnt_q   <= '0;
        bcnt_q   <= '0;
        data_q   <= '0;
        dlast_q  <= 1'b0;
        dvalid_q <= 1'b0;
        cvalid_q <= 1'b0;
        rdy_q    <= 1'b1;
        csize_q  <= '0;
      end else begin
        unique case (state_q)
          FILL: begin
            if (acc) begin
              data_q[base +: 32] <= mw;
              wcnt_q <= wcnt_q + 4'd1;
              bcnt_q <= bcnt_d;
              if (bus.word_in_last || wcnt_q == 4'd15) begin
                state_q  <= SEND;
                rdy_q    <= 1'b0;
                dvalid_q <= 1'b1;
                dlast_q  <= bus.word_in_last;
                if (bus.word_in_last) begin
                  cvalid_q <= 1'b1;
                  csize_q  <= {bcnt_d, 3'b000};
                end
              end
            end
          end
          SEND: begin
            if (dvalid_q && bus.data_out_ready) dvalid_q <= 1'b0;
            if (cvalid_q && bus.cfg_ready)      cvalid_q <= 1'b0;
            // Slots are cleared here so a short next block is zero-padded
            if (done) begin
              state_q <= FILL;
              rdy_q   <= 1'b1;
              wcnt_q  <= '0;
              data_q  <= '0;
              dlast_q <= 1'b0;
              if (dlast_q) bcnt_q <= '0;
            end
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  assign bus.word_in_ready  = rdy_q;
  assign bus.data_out       = data_q;
  assign bus.data_out_last  = dlast_q;
  assign bus.data_out_valid = dvalid_q;
  assign bus.cfg_size       = csize_q;
  assign bus.cfg_scheme     = SCHEME_ID;
  assign bus.cfg_last       = 1'b1;
  assign bus.cfg_valid      = cvalid_q;

endmodule

// File: tb/tb_sha256_message_packer.sv
// Bench for sha256_message_packer: byte-stream reference model,
// per-cycle compare process, directed and randomized messages.
module tb_sha256_message_packer;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic sync_rst;

  sha256_message_packer_if bus();

  sha256_message_packer #(.SCHEME_ID(2'd0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_rst (sync_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] d;
    logic         l;
  } blk_t;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0]  raw [64];
  blk_t         exp_blk [$];
  logic [63:0]  exp_cfg [$];
  logic [511:0] got_blk [$];
  logic         got_last [$];
  logic [63:0]  got_cfg [$];
  bit           auto_rdy = 1'b0;

  function automatic void chk(string nm, logic [511:0] act,
                              logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Word whose packed (post-swap) form is p
  function automatic logic [31:0] inw(logic [31:0] p);
`ifdef SHA256_PACKER_BYTESWAP_EN
    return {p[7:0], p[15:8], p[23:16], p[31:24]};
`else
    return p;
`endif
  endfunction

  // Reference: message as a byte stream, cut into 64-byte blocks
  function automatic void model_push(int n, logic [1:0] b);
    logic [7:0] q [$];
    int nb;
    blk_t e;
    for (int i = 0; i < n; i++) begin
      nb = (i == n - 1 && b != 2'd0) ? int'(b) : 4;
      for (int k = 0; k < nb; k++) begin
`ifdef SHA256_PACKER_BYTESWAP_EN
        q.push_back(raw[i][8*k +: 8]);
`else
        q.push_back(raw[i][31-8*k -: 8]);
`endif
      end
    end
    for (int s = 0; s < q.size(); s += 64) begin
      e.d = '0;
      for (int j = 0; j < 64; j++)
        if (s + j < q.size()) e.d[511-8*j -: 8] = q[s+j];
      e.l = (s + 64 >= q.size());
      exp_blk.push_back(e);
    end
    exp_cfg.push_back(64'(q.size()) * 64'd8);
  endfunction

  int           wc = 0;
  bit           close_p = 1'b0;
  bit           close_last = 1'b0;
  bit           pd = 1'b0;
  bit           pc = 1'b0;
  bit           psr = 1'b0;
  logic [511:0] pdd;
  logic         pdl;
  logic [63:0]  pcs;

  always @(negedge clk) begin
    blk_t e;
    logic [63:0] c;
    if (!rst) begin
      if (close_p) begin
        chk("latency_dv", bus.data_out_valid, 1);
        if (close_last) chk("latency_cv", bus.cfg_valid, 1);
      end
      if (pd && !psr) begin
        chk("hold_dv", bus.data_out_valid, 1);
        chk("hold_data", bus.data_out, pdd);
        chk("hold_dlast", bus.data_out_last, pdl);
      end
      if (pc && !psr) begin
        chk("hold_cv", bus.cfg_valid, 1);
        chk("hold_size", bus.cfg_size, pcs);
      end
      if (bus.data_out_valid || bus.cfg_valid)
        chk("rdy_in_send", bus.word_in_ready, 0);
      if (en && !sync_rst) begin
        if (bus.data_out_valid && bus.data_out_ready) begin
          got_blk.push_back(bus.data_out);
          got_last.push_back(bus.data_out_last);
          if (exp_blk.size() == 0) chk("spurious_blk", 1, 0);
          else begin
            e = exp_blk.pop_front();
            chk("blk_data", bus.data_out, e.d);
            chk("blk_last", bus.data_out_last, e.l);
          end
        end
        if (bus.cfg_valid && bus.cfg_ready) begin
          got_cfg.push_back(bus.cfg_size);
          chk("cfg_scheme", bus.cfg_scheme, 0);
          chk("cfg_last", bus.cfg_last, 1);
          if (exp_cfg.size() == 0) chk("spurious_cfg", 1, 0);
          else begin
            c = exp_cfg.pop_front();
            chk("cfg_size", bus.cfg_size, c);
          end
        end
      end
      close_p = 1'b0;
      if (en && sync_rst) wc = 0;
      else if (en && bus.word_in_valid && bus.word_in_ready) begin
        wc++;
        if (bus.word_in_last || wc == 16) begin
          close_p = 1'b1;
          close_last = bus.word_in_last;
          wc = 0;
        end
      end
      pd  = bus.data_out_valid && !(en && bus.data_out_ready);
      pc  = bus.cfg_valid && !(en && bus.cfg_ready);
      pdd = bus.data_out;
      pdl = bus.data_out_last;
      pcs = bus.cfg_size;
      psr = en && sync_rst;
    end
  end

  always @(posedge clk) begin
    if (auto_rdy) begin
      #1;
      en = ($urandom % 6) != 0;
      bus.data_out_ready = ($urandom % 3) != 0;
      bus.cfg_ready = ($urandom % 3) != 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_msg(input int n, input logic [1:0] b,
                          input int gap_at, input bit with_last,
                          input bit push);
    bit acc;
    int t;
    if (push) model_push(n, b);
    for (int i = 0; i < n; i++) begin
      bus.word_in = raw[i];
      bus.word_in_last = with_last && (i == n - 1);
      bus.word_in_bytes = (i == n - 1) ? b : 2'($urandom);
      bus.word_in_valid = 1'b1;
      if (i == gap_at) begin
        en = 1'b0;
        repeat (5) tick();
        en = 1'b1;
      end
      acc = 1'b0;
      t = 0;
      while (!acc && t < 300) begin
        @(negedge clk);
        acc = bus.word_in_ready && en;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) chk("word_timeout", 0, 1);
    end
    bus.word_in_valid = 1'b0;
    bus.word_in_last = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_blk.size() != 0 || exp_cfg.size() != 0) && t < 400) begin
      tick();
      t++;
    end
    if (t >= 400) chk("drain_timeout", 0, 1);
    tick();
  endtask

  task automatic clear_got();
    got_blk.delete();
    got_last.delete();
    got_cfg.delete();
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    sync_rst = 1'b0;
    bus.word_in = '0;
    bus.word_in_bytes = '0;
    bus.word_in_last = 1'b0;
    bus.word_in_valid = 1'b0;
    bus.data_out_ready = 1'b1;
    bus.cfg_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dv", bus.data_out_valid, 0);
    chk("rst_cv", bus.cfg_valid, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_dlast", bus.data_out_last, 0);
    chk("rst_size", bus.cfg_size, 0);
    chk("rst_ready", bus.word_in_ready, 1);
    tick();

    clear_got();
    for (int i = 0; i < 16; i++) raw[i] = inw(32'(i + 1));
    send_msg(16, 2'd0, -1, 1'b1, 1'b1);
    drain();
    chk("t16_nblk", got_blk.size(), 1);
    if (got_blk.size() == 1) begin
      chk("t16_w0", got_blk[0][511:480], 32'h1);
      chk("t16_w15", got_blk[0][31:0], 32'h10);
      chk("t16_last", got_last[0], 1);
    end
    if (got_cfg.size() == 1) chk("t16_size", got_cfg[0], 512);

    clear_got();
    raw[0] = inw(32'h6162_6300);
    send_msg(1, 2'd3, -1, 1'b1, 1'b1);
    drain();
    if (got_blk.size() == 1)
      chk("abc_blk", got_blk[0], {32'h6162_6300, 480'h0});
    if (got_cfg.size() == 1) chk("abc_size", got_cfg[0], 24);

    clear_got();
    for (int i = 0; i < 20; i++) raw[i] = inw({4{8'(i + 1)}});
    send_msg(20, 2'd2, -1, 1'b1, 1'b1);
    drain();
    chk("t20_nblk", got_blk.size(), 2);
    chk("t20_ncfg", got_cfg.size(), 1);
    if (got_blk.size() == 2) begin
      chk("t20_last0", got_last[0], 0);
      chk("t20_last1", got_last[1], 1);
      chk("t20_tail", got_blk[1][511:384],
          {32'h1111_1111, 32'h1212_1212, 32'h1313_1313, 32'h1414_0000});
    end
    if (got_cfg.size() == 1) chk("t20_size", got_cfg[0], 624);

    raw[0] = inw(32'hDEAD_BEEF);
    bus.data_out_ready = 1'b0;
    send_msg(1, 2'd0, -1, 1'b1, 1'b1);
    repeat (10) tick();
    @(negedge clk);
    chk("stl_dv", bus.data_out_valid, 1);
    chk("stl_cv", bus.cfg_valid, 0);
    chk("stl_rdy", bus.word_in_ready, 0);
    tick();
    bus.data_out_ready = 1'b1;
    drain();

    raw[0] = inw(32'h0BAD_F00D);
    bus.cfg_ready = 1'b0;
    send_msg(1, 2'd0, -1, 1'b1, 1'b1);
    repeat (10) tick();
    @(negedge clk);
    chk("stl2_dv", bus.data_out_valid, 0);
    chk("stl2_cv", bus.cfg_valid, 1);
    chk("stl2_rdy", bus.word_in_ready, 0);
    tick();
    bus.cfg_ready = 1'b1;
    drain();

    clear_got();
    for (int i = 0; i < 7; i++) raw[i] = $urandom;
    send_msg(7, 2'd0, -1, 1'b0, 1'b0);
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    raw[0] = inw(32'hAA00_0000);
    send_msg(1, 2'd1, -1, 1'b1, 1'b1);
    drain();
    chk("srst_nblk", got_blk.size(), 1);
    if (got_blk.size() == 1)
      chk("srst_blk", got_blk[0], {32'hAA00_0000, 480'h0});
    if (got_cfg.size() == 1) chk("srst_size", got_cfg[0], 8);

    for (int i = 0; i < 12; i++) raw[i] = $urandom;
    send_msg(12, 2'd0, 5, 1'b1, 1'b1);
    drain();

    auto_rdy = 1'b1;
    for (int m = 0; m < 30; m++) begin
      int n;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) raw[i] = $urandom;
      send_msg(n, 2'($urandom), -1, 1'b1, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    auto_rdy = 1'b0;
    tick();
    en = 1'b1;
    bus.data_out_ready = 1'b1;
    bus.cfg_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sha256_message_packer.md
Name: sha256_message_packer

Overview:
- Source-side front end for the SHA-256 engine.
- Accepts a stream of 32-bit message words with valid/ready/last, and packs them big-endian into 512-bit blocks on the engine's data-in channel.
- Counts message length and emits one config packet per message: size in bits, scheme, last.
- Sits between the bus/DMA word interface and the engine's data-in and config inputs.

Parameters:
- SCHEME_ID, 2'd0, value driven on cfg_scheme for every message.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  clock enable; when low, all state, counters and outputs hold
- sync_rst  in  1  synchronous reset; same effect as rst, but on the clk edge when en=1
- word_in  in  32  message word; first byte in [31:24]
- word_in_bytes  in  2  valid bytes in the last word (0 encodes 4); ignored unless word_in_last
- word_in_last  in  1  final word of the message
- word_in_valid  in  1  handshake
- word_in_ready  out  1  handshake
- data_out  out  512  packed block; word 0 in [511:480]
- data_out_last  out  1  final block of the message
- data_out_valid  out  1  handshake
- data_out_ready  in  1  handshake
- cfg_size  out  64  message length in bits
- cfg_scheme  out  2  = SCHEME_ID
- cfg_last  out  1  always 1 while cfg_valid
- cfg_valid  out  1  handshake
- cfg_ready  in  1  handshake

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- Reset values: state=FILL; word_cnt=0; byte_cnt=0; data_out=0; data_out_last=0; data_out_valid=0; cfg_valid=0; cfg_size=0; word_in_ready=1.
- Handshakes:
  - A transfer occurs on a clk edge with en=1 and valid&ready both high.
  - Once a valid output is asserted, it and its payload stay stable until accepted.
- State FILL:
  - word_in_ready=1.
  - Each accepted word is written to slot word_cnt. word_cnt increments, and byte_cnt increases by 4, or by word_in_bytes (0 counts as 4) when last.
  - On a last word, bytes beyond word_in_bytes are zeroed, high-order bytes kept: 1 keeps [31:24], 2 keeps [31:16], 3 keeps [31:8].
  - Go to SEND when the 16th word is accepted, or when word_in_last is accepted.
- Entering SEND:
  - Unfilled slots are zero; data_out_valid=1 on the next cycle, so latency from the final word to valid is 1 cycle.
  - data_out_last=1 if the block closed on word_in_last.
  - If last: cfg_valid=1 in the same cycle, with cfg_size={byte_cnt including this word, 3'b000}.
- State SEND:
  - word_in_ready=0.
  - data_out and cfg complete independently and in either order; each valid drops after its own handshake.
  - Return to FILL once every asserted valid has completed.
  - Leaving a last message clears byte_cnt; word_cnt always clears.
  - Both handshakes in the same cycle return to FILL on the next cycle.
- Throughput: at most one block per 17 cycles; word input is stalled during SEND, with no bypass.
- Exactly 16 words with last on word 16: one block, data_out_last=1, no extra empty block.
- Empty messages are unsupported: every message carries at least one last word.
- byte_cnt is 61 bits and wraps modulo 2^61; no overflow flag.
- Reset mid-operation (rst or sync_rst):
  - A partial block is discarded and pending valids drop.
  - No cfg packet is emitted for the aborted message.
- en=0 during a pending handshake: no transfer occurs and the outputs hold.

Optional Feature:
- Macro SHA256_PACKER_BYTESWAP_EN.
- Defined: each word_in is byte-reversed before packing, for little-endian sources. The first byte is then word_in[7:0]. Last-word masking keeps the lowest word_in_bytes bytes of the original word, applied after the swap.
- Undefined: words are packed as received; no swap logic is present.

Test Plan:
- 16 words 0x00000001..0x00000010, last on word 16, bytes=0 -> one block, data_out[511:480]=0x00000001, [31:0]=0x00000010, last=1; cfg_size=512, cfg_scheme=0, cfg_last=1.
- "abc" as one word 0x61626300, last, bytes=3 -> block = 0x61626300 followed by 480 zero bits, last=1; cfg_size=24; valid 1 cycle after the word is accepted.
- 20 words, last on word 20, bytes=2 ->
  - Block 1: last=0, no cfg.
  - Block 2: words 17..20 with word 20 masked to [31:16], last=1; cfg_size=(76+2)*8=624.
- Stall data_out_ready=0 for 10 cycles while cfg_ready=1 ->
  - cfg accepted first; data_out stable throughout; word_in_ready=0 until the block is accepted.
  - Then the reverse order: cfg held stable while the block is accepted first.
- Assert sync_rst after 7 words, then a fresh 1-word message, bytes=1, 0xAA000000 -> no output from the aborted words; block [511:480]=0xAA000000; cfg_size=8.
- en=0 for 5 cycles mid-FILL with word_in_valid=1 -> word_cnt unchanged, no words lost or duplicated; the resulting block matches the en=1 reference.
